// File: rtl/ram_mport_sync_pkg.sv
// Shared types and constants for the multi-read-port synchronous RAM.
// Optional byte-enable build is selected with RAM_MPORT_BYTE_WE_EN.
package ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } ram_state_e;

  localparam int MAX_NUM_RD = 8;

  // Word count for a given address width; a zero-width address still means one word.
  function automatic int ram_depth(input int aw);
    if (aw <= 0) begin
      return 1;
    end
    return 1 << aw;
  endfunction

endpackage

// File: rtl/ram_mport_sync_rd_port.sv
// One registered read port: write-first bypass mux, data register, valid register.
// r_data holds its last value whenever no read is issued.
module ram_rd_port #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_en,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_mem_word,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic [DATA_WIDTH-1:0] i_wr_mask,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid
);

  logic                  w_hit;
  logic [DATA_WIDTH-1:0] w_word;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;

  // A same-cycle write to our address wins, merged bitwise with the stored word.
  assign w_hit  = i_wr_en && (i_wr_addr == i_addr);
  assign w_word = w_hit ? ((i_mem_word & ~i_wr_mask) | (i_wr_data & i_wr_mask))
                        : i_mem_word;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_en;
      if (i_en) begin
        r_data <= w_word;
      end
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/ram_mport_sync.sv
// Multi-read-port synchronous RAM with a post-reset clear engine.
// Define RAM_MPORT_BYTE_WE_EN to add the per-byte write enable port w_be.
module ram_mport_sync
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_RD     = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           w_en,
  input  logic [ADDR_WIDTH-1:0]          w_addr,
  input  logic [DATA_WIDTH-1:0]          w_data,
`ifdef RAM_MPORT_BYTE_WE_EN
  input  logic [DATA_WIDTH/8-1:0]        w_be,
`endif
  output logic                           w_ready,
  input  logic [NUM_RD-1:0]              r_en,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]   r_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0]   r_data,
  output logic [NUM_RD-1:0]              r_valid,
  output logic                           init_done,
  output logic                           o_dbg_state
);

  localparam int DEPTH = ram_depth(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  ram_state_e            r_state;
  logic [ADDR_WIDTH-1:0] r_clr_ptr;
  logic                  r_init_done;

  logic                  w_is_ready;
  logic                  w_wr_act;
  logic [DATA_WIDTH-1:0] w_wmask;

  assign w_is_ready = (r_state == READY);
  assign w_wr_act   = w_is_ready && w_en;

`ifdef RAM_MPORT_BYTE_WE_EN
  always_comb begin
    w_wmask = '0;
    for (int b = 0; b < DATA_WIDTH / 8; b++) begin
      w_wmask[b*8 +: 8] = {8{w_be[b]}};
    end
  end
`else
  assign w_wmask = '1;
`endif

  // Clear walks every address once, then the RAM stays READY until the next reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= CLEAR;
      r_clr_ptr   <= '0;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        CLEAR: begin
          r_clr_ptr <= r_clr_ptr + ADDR_WIDTH'(1);
          if (r_clr_ptr == LAST_ADDR) begin
            r_state     <= READY;
            r_init_done <= 1'b1;
          end
        end
        READY: begin
          r_state <= READY;
        end
        default: begin
          r_state <= CLEAR;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (r_state == CLEAR) begin
        r_mem[r_clr_ptr] <= '0;
      end else if (w_wr_act) begin
        r_mem[w_addr] <= (r_mem[w_addr] & ~w_wmask) | (w_data & w_wmask);
      end
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR_WIDTH-1:0] w_port_addr;
    assign w_port_addr = r_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];

    ram_rd_port #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_rd (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_en       (r_en[gi] && w_is_ready),
      .i_addr     (w_port_addr),
      .i_mem_word (r_mem[w_port_addr]),
      .i_wr_en    (w_wr_act),
      .i_wr_addr  (w_addr),
      .i_wr_data  (w_data),
      .i_wr_mask  (w_wmask),
      .o_data     (r_data[gi*DATA_WIDTH +: DATA_WIDTH]),
      .o_valid    (r_valid[gi])
    );
  end

  assign init_done   = r_init_done;
  assign w_ready     = r_init_done;
  assign o_dbg_state = (r_state == READY);

endmodule

// File: tb/tb_ram_mport_sync.sv
// Self-checking bench for ram_mport_sync with a reference memory and per-port expected queues.
// Build with RAM_MPORT_BYTE_WE_EN defined to exercise byte enables on a 16-bit word.
module tb_ram_mport_sync;

  localparam int AW = 3;
`ifdef RAM_MPORT_BYTE_WE_EN
  localparam int DW = 16;
`else
  localparam int DW = 8;
`endif
  localparam int BW    = DW / 8;
  localparam int NR    = 2;
  localparam int DEPTH = 1 << AW;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              w_en;
  logic [AW-1:0]     w_addr;
  logic [DW-1:0]     w_data;
  logic [BW-1:0]     w_be;
  logic              w_ready;
  logic [NR-1:0]     r_en;
  logic [NR*AW-1:0]  r_addr;
  logic [NR*DW-1:0]  r_data;
  logic [NR-1:0]     r_valid;
  logic              init_done;
  logic              dbg_state;

  ram_mport_sync #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_RD     (NR)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .w_en        (w_en),
    .w_addr      (w_addr),
    .w_data      (w_data),
`ifdef RAM_MPORT_BYTE_WE_EN
    .w_be        (w_be),
`endif
    .w_ready     (w_ready),
    .r_en        (r_en),
    .r_addr      (r_addr),
    .r_data      (r_data),
    .r_valid     (r_valid),
    .init_done   (init_done),
    .o_dbg_state (dbg_state)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model and scoreboard state
  logic [DW-1:0] model_mem [DEPTH];
  bit            model_ready = 1'b0;
  bit            mon_en      = 1'b0;
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  int            due_q0[$];
  int            due_q1[$];
  logic [DW-1:0] last0, last1;
  int            n_checks = 0;
  int            n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] res;
    res = old_w;
    for (int b = 0; b < BW; b++) begin
      if (be[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return res;
  endfunction

  // Driver: one call drives one cycle of inputs
  task automatic drive_cycle(input bit we, input int wa, input logic [DW-1:0] wd,
                             input logic [BW-1:0] be, input logic [1:0] re,
                             input int ra0, input int ra1);
    logic [AW-1:0] a0, a1, aw;
    @(posedge clk); #1;
    a0 = AW'(ra0);
    a1 = AW'(ra1);
    aw = AW'(wa);
    w_en   = we;
    w_addr = aw;
    w_data = wd;
    w_be   = be;
    r_en   = re;
    r_addr = {a1, a0};
    if (model_ready) begin
      if (re[0]) begin
        exp_q0.push_back((we && aw == a0) ? merge(model_mem[a0], wd, be) : model_mem[a0]);
        due_q0.push_back(cyc + 1);
      end
      if (re[1]) begin
        exp_q1.push_back((we && aw == a1) ? merge(model_mem[a1], wd, be) : model_mem[a1]);
        due_q1.push_back(cyc + 1);
      end
      if (we) model_mem[aw] = merge(model_mem[aw], wd, be);
    end
  endtask

  task automatic idle_cycle();
    drive_cycle(1'b0, 0, '0, '0, 2'b00, 0, 0);
  endtask

  // Reset pulse, then hold write/read traffic on the inputs while the clear runs
  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    w_en = 1'b0; r_en = '0;
    model_ready = 1'b0;
    @(posedge clk); #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    last0  = '0;
    last1  = '0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    w_en = 1'b1; w_addr = AW'(2); w_data = '1; w_be = '1;
    r_en = 2'b01; r_addr = {AW'(0), AW'(2)};
    @(negedge clk);
    chk("rst_init_done", init_done, 0);
    chk("rst_w_ready", w_ready, 0);
    chk("rst_valid", r_valid, 0);
    for (int k = 1; k <= DEPTH; k++) begin
      @(negedge clk);
      chk("clr_init_done", init_done, (k == DEPTH) ? 1 : 0);
      chk("clr_w_ready", w_ready, (k == DEPTH) ? 1 : 0);
      chk("clr_dbg_state", dbg_state, (k == DEPTH) ? 1 : 0);
    end
    w_en = 1'b0; r_en = '0;
    model_ready = 1'b1;
  endtask

  // Monitor: compare due reads, otherwise require valid low and data held
  always @(negedge clk) begin
    if (mon_en) begin
      if (due_q0.size() > 0 && due_q0[0] == cyc) begin
        chk("p0_valid", r_valid[0], 1);
        chk("p0_data", r_data[0 +: DW], exp_q0[0]);
        last0 = exp_q0.pop_front();
        void'(due_q0.pop_front());
      end else begin
        chk("p0_idle_valid", r_valid[0], 0);
        chk("p0_hold", r_data[0 +: DW], last0);
      end
      if (due_q1.size() > 0 && due_q1[0] == cyc) begin
        chk("p1_valid", r_valid[1], 1);
        chk("p1_data", r_data[DW +: DW], exp_q1[0]);
        last1 = exp_q1.pop_front();
        void'(due_q1.pop_front());
      end else begin
        chk("p1_idle_valid", r_valid[1], 0);
        chk("p1_hold", r_data[DW +: DW], last1);
      end
    end
  end

  initial begin
    logic [BW-1:0] rbe;
    rst_n = 1'b0; w_en = 1'b0; w_addr = '0; w_data = '0; w_be = '0;
    r_en = '0; r_addr = '0;

    do_reset();

    // Every address reads zero after the clear
    for (int a = 0; a < DEPTH; a++) drive_cycle(1'b0, 0, '0, '1, 2'b11, a, DEPTH - 1 - a);
    idle_cycle();

    // Plain write then dual read of the same address
    drive_cycle(1'b1, 3, DW'(8'hA5), '1, 2'b00, 0, 0);
    drive_cycle(1'b0, 0, '0, '1, 2'b11, 3, 3);
    idle_cycle();

    // Write-first collision on port 0, ordinary read on port 1
    drive_cycle(1'b1, 4, DW'(8'h11), '1, 2'b00, 0, 0);
    drive_cycle(1'b1, 5, DW'(8'h3C), '1, 2'b11, 5, 4);
    idle_cycle();
    drive_cycle(1'b0, 0, '0, '1, 2'b11, 5, 5);
    idle_cycle();

`ifdef RAM_MPORT_BYTE_WE_EN
    drive_cycle(1'b1, 1, 16'hBEEF, 2'b11, 2'b00, 0, 0);
    drive_cycle(1'b1, 1, 16'h1234, 2'b01, 2'b00, 0, 0);
    drive_cycle(1'b1, 1, 16'hFFFF, 2'b00, 2'b00, 0, 0);
    drive_cycle(1'b0, 0, '0, '1, 2'b11, 1, 1);
    drive_cycle(1'b1, 1, 16'h5600, 2'b10, 2'b01, 1, 0);
    idle_cycle();
`endif

    // Random mixed traffic
    for (int i = 0; i < 80; i++) begin
      rbe = '1;
`ifdef RAM_MPORT_BYTE_WE_EN
      rbe = BW'($urandom_range(0, (1 << BW) - 1));
`endif
      drive_cycle(1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1),
                  DW'($urandom), rbe, 2'($urandom_range(0, 3)),
                  $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1));
    end
    idle_cycle();

    // Fill with nonzero data, leave a read in flight, then reset
    for (int a = 0; a < DEPTH; a++) drive_cycle(1'b1, a, DW'(8'h80 | a), '1, 2'b00, 0, 0);
    drive_cycle(1'b0, 0, '0, '1, 2'b11, 6, 7);
    do_reset();
    for (int a = 0; a < DEPTH; a++) drive_cycle(1'b0, 0, '0, '1, 2'b11, a, a);
    repeat (3) idle_cycle();

    @(negedge clk);
    chk("q0_drained", exp_q0.size(), 0);
    chk("q1_drained", exp_q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
